gcd_result_bcd: RTL and testbench

Sequential binary-to-BCD converter between `gcd_engine` and the seven-segment decoders. It accepts one binary result per `in_valid`/`in_ready` handshake and converts it with an iterative shift-and-add-3 (double-dabble) datapath, one bit per clock. It presents registered hundreds, tens and ones digits that hold stable between conversions, so the display path sees no intermediate values.

---
 rtl/gcd_pkg.sv | 18 +
 rtl/gcd_result_bcd_add3.sv | 16 +
 rtl/gcd_result_bcd.sv | 129 ++++++++++++
 tb/tb_gcd_result_bcd.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD datapath and its display path:
// controller state encoding, BCD digit width and the display limit.
package gcd_pkg;

   // Width of one BCD digit.
   localparam int BCD_W = 4;

   // Largest value the two-digit display can show; anything above is an error.
   localparam logic [9:0] MAX_DISP = 10'd99;

   // Controller states of the BCD result converter.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/gcd_result_bcd_add3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before
// the shift, so that the doubled value carries correctly into the next digit.
module bcd_add3
   import gcd_pkg::*;
(
   input  logic [BCD_W-1:0] d,
   output logic [BCD_W-1:0] q
);

   // Add 3 to digits 5..9; the result stays within 4 bits.
   always_comb begin
      q = d;
      if (d >= 4'd5) q = d + 4'd3;
   end

endmodule

// File: rtl/gcd_result_bcd.sv
// Sequential binary-to-BCD converter between the GCD engine and the
// seven-segment decoders. One result is accepted per in_valid/in_ready
// handshake and converted one bit per clock; the committed digits are
// registered and only change on the commit edge.
//
// Handshake: a transfer happens on a rising edge where in_valid && in_ready
// are both high. in_ready is high only in IDLE, so in_valid outside IDLE is
// ignored and nothing is queued. out_valid is a one-cycle pulse in the cycle
// after the new digits are committed; there is no backpressure on the output.
module gcd_result_bcd
   import gcd_pkg::*;
#(
   parameter int W = 7
) (
   input  logic               CLOCK_50,
   input  logic               rst,
   input  logic               in_valid,
   input  logic [W-1:0]       in_data,
   output logic               in_ready,
   output logic               busy,
   output logic [BCD_W-1:0]   bcd_hund,
   output logic [BCD_W-1:0]   bcd_tens,
   output logic [BCD_W-1:0]   bcd_ones,
   output logic               over99,
   output logic               out_valid,
   output logic [1:0]         dbg_state
);

   localparam int CW = $clog2(W + 1);
   localparam int SW = 3 * BCD_W;

   state_t            state_q, state_d;
   logic [W-1:0]      bin_q, bin_d;
   logic [SW-1:0]     scr_q, scr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              over_q, over_d;
   logic [BCD_W-1:0]  hund_q, hund_d;
   logic [BCD_W-1:0]  tens_q, tens_d;
   logic [BCD_W-1:0]  ones_q, ones_d;
   logic              over99_q, over99_d;
   logic              out_valid_q, out_valid_d;

   logic [SW-1:0]     adj;
   logic [SW+W-1:0]   shf;

   // Per-digit +3 correction in front of the shifter.
   bcd_add3 u_add3_hund (.d(scr_q[3*BCD_W-1:2*BCD_W]), .q(adj[3*BCD_W-1:2*BCD_W]));
   bcd_add3 u_add3_tens (.d(scr_q[2*BCD_W-1:BCD_W]),   .q(adj[2*BCD_W-1:BCD_W]));
   bcd_add3 u_add3_ones (.d(scr_q[BCD_W-1:0]),         .q(adj[BCD_W-1:0]));

   // Next-state, datapath and commit logic.
   always_comb begin
      state_d     = state_q;
      bin_d       = bin_q;
      scr_d       = scr_q;
      cnt_d       = cnt_q;
      over_d      = over_q;
      hund_d      = hund_q;
      tens_d      = tens_q;
      ones_d      = ones_q;
      over99_d    = over99_q;
      out_valid_d = 1'b0;
      shf         = {adj, bin_q} << 1;

      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               bin_d   = in_data;
               scr_d   = '0;
               over_d  = (10'(in_data) > MAX_DISP);
               cnt_d   = CW'(W);
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            scr_d = shf[SW+W-1:W];
            bin_d = shf[W-1:0];
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = ST_DONE;
         end
         ST_DONE: begin
            hund_d      = scr_q[3*BCD_W-1:2*BCD_W];
            tens_d      = scr_q[2*BCD_W-1:BCD_W];
            ones_d      = scr_q[BCD_W-1:0];
            over99_d    = over_q;
            out_valid_d = 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any conversion.
   always_ff @(posedge CLOCK_50) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         bin_q       <= '0;
         scr_q       <= '0;
         cnt_q       <= '0;
         over_q      <= 1'b0;
         hund_q      <= '0;
         tens_q      <= '0;
         ones_q      <= '0;
         over99_q    <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bin_q       <= bin_d;
         scr_q       <= scr_d;
         cnt_q       <= cnt_d;
         over_q      <= over_d;
         hund_q      <= hund_d;
         tens_q      <= tens_d;
         ones_q      <= ones_d;
         over99_q    <= over99_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   assign bcd_hund  = hund_q;
   assign bcd_tens  = tens_q;
   assign bcd_ones  = ones_q;
   assign over99    = over99_q;
   assign out_valid = out_valid_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_gcd_result_bcd.sv
// Bench for gcd_result_bcd: a W=7 instance for the directed cases and a
// W=9 instance for the wide sweep. Inputs are driven and outputs sampled
// on the falling edge of CLOCK_50.
module tb_gcd_result_bcd;
   import gcd_pkg::*;

   // Clock and reset
   logic CLOCK_50 = 1'b0;
   always #10 CLOCK_50 = ~CLOCK_50;
   logic rst;

   // W=7 instance signals
   logic       in_valid7;
   logic [6:0] in_data7;
   logic       in_ready7, busy7, over99_7, out_valid7;
   logic [3:0] bcd_hund7, bcd_tens7, bcd_ones7;
   logic [1:0] dbg_state7;

   // W=9 instance signals
   logic       in_valid9;
   logic [8:0] in_data9;
   logic       in_ready9, busy9, over99_9, out_valid9;
   logic [3:0] bcd_hund9, bcd_tens9, bcd_ones9;
   logic [1:0] dbg_state9;

   gcd_result_bcd #(.W(7)) dut7 (
      .CLOCK_50(CLOCK_50), .rst(rst), .in_valid(in_valid7), .in_data(in_data7),
      .in_ready(in_ready7), .busy(busy7), .bcd_hund(bcd_hund7), .bcd_tens(bcd_tens7),
      .bcd_ones(bcd_ones7), .over99(over99_7), .out_valid(out_valid7), .dbg_state(dbg_state7)
   );

   gcd_result_bcd #(.W(9)) dut9 (
      .CLOCK_50(CLOCK_50), .rst(rst), .in_valid(in_valid9), .in_data(in_data9),
      .in_ready(in_ready9), .busy(busy9), .bcd_hund(bcd_hund9), .bcd_tens(bcd_tens9),
      .bcd_ones(bcd_ones9), .over99(over99_9), .out_valid(out_valid9), .dbg_state(dbg_state9)
   );

   // Scoreboard: {hund, tens, ones, over99}
   logic [12:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   logic [12:0] prev7;

   typedef struct {
      logic [8:0] value;
      logic [3:0] hund;
      logic [3:0] tens;
      logic [3:0] ones;
      logic       over;
   } vec_t;
   vec_t vecs[5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [12:0] model(input int v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10), (v > 99)};
   endfunction

   // Driver for the W=7 instance: one-cycle request, then wait for commit.
   task automatic conv7(input logic [6:0] v);
      int e;
      int lowc;
      bit hold_ok;
      logic [12:0] exp;
      in_valid7 = 1'b1;
      in_data7  = v;
      @(negedge CLOCK_50);
      in_valid7 = 1'b0;
      in_data7  = ~v;
      e = 0;
      lowc = 0;
      hold_ok = 1'b1;
      while (!out_valid7 && e < 30) begin
         if (!in_ready7) lowc++;
         if ({bcd_hund7, bcd_tens7, bcd_ones7, over99_7} !== prev7) hold_ok = 1'b0;
         @(negedge CLOCK_50);
         e++;
      end
      check("out_valid_seen7", 32'(out_valid7), 32'd1);
      check("latency7", 32'(e), 32'd8);
      check("ready_low_cycles7", 32'(lowc), 32'd8);
      check("digits_hold7", 32'(hold_ok), 32'd1);
      exp = exp_q.pop_front();
      check("digits7", 32'({bcd_hund7, bcd_tens7, bcd_ones7, over99_7}), 32'(exp));
      check("ready_at_commit7", 32'({in_ready7, busy7}), 32'b10);
      prev7 = exp;
      @(negedge CLOCK_50);
      check("pulse_width7", 32'(out_valid7), 32'd0);
   endtask

   // Driver for the W=9 instance.
   task automatic conv9(input logic [8:0] v);
      int e;
      logic [12:0] exp;
      in_valid9 = 1'b1;
      in_data9  = v;
      @(negedge CLOCK_50);
      in_valid9 = 1'b0;
      e = 0;
      while (!out_valid9 && e < 30) begin
         @(negedge CLOCK_50);
         e++;
      end
      check("latency9", 32'(e), 32'd10);
      exp = exp_q.pop_front();
      check("digits9", 32'({bcd_hund9, bcd_tens9, bcd_ones9, over99_9}), 32'(exp));
      @(negedge CLOCK_50);
   endtask

   // Global time limit
   initial begin
      #5ms;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int first, second;
      bit saw_ov;

      vecs[0] = '{9'd6,   4'd0, 4'd0, 4'd6, 1'b0};
      vecs[1] = '{9'd99,  4'd0, 4'd9, 4'd9, 1'b0};
      vecs[2] = '{9'd100, 4'd1, 4'd0, 4'd0, 1'b1};
      vecs[3] = '{9'd127, 4'd1, 4'd2, 4'd7, 1'b1};
      vecs[4] = '{9'd0,   4'd0, 4'd0, 4'd0, 1'b0};

      rst = 1'b1;
      in_valid7 = 1'b0; in_data7 = '0;
      in_valid9 = 1'b0; in_data9 = '0;
      prev7 = '0;

      // Reset
      repeat (2) @(negedge CLOCK_50);
      rst = 1'b0;
      check("reset_digits7", 32'({bcd_hund7, bcd_tens7, bcd_ones7, over99_7}), 32'd0);
      check("reset_flags7", 32'({out_valid7, in_ready7, busy7}), 32'b010);
      check("reset_state7", 32'(dbg_state7), 32'(ST_IDLE));
      check("reset_flags9", 32'({out_valid9, in_ready9, busy9}), 32'b010);

      // Single value and boundary values from the table
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back({vecs[i].hund, vecs[i].tens, vecs[i].ones, vecs[i].over});
         conv7(vecs[i].value[6:0]);
      end

      // Level-held in_valid: 42 then 57, period W+2
      exp_q.push_back(model(42));
      exp_q.push_back(model(57));
      in_valid7 = 1'b1;
      in_data7  = 7'd42;
      first = -1;
      second = -1;
      for (int k = 1; k <= 40 && second < 0; k++) begin
         @(negedge CLOCK_50);
         if (k == 3) in_data7 = 7'd57;
         if (out_valid7) begin
            if (first < 0) begin
               first = k;
               check("level_first", 32'({bcd_hund7, bcd_tens7, bcd_ones7, over99_7}), 32'(exp_q.pop_front()));
            end else begin
               second = k;
               in_valid7 = 1'b0;
               check("level_second", 32'({bcd_hund7, bcd_tens7, bcd_ones7, over99_7}), 32'(exp_q.pop_front()));
            end
         end
      end
      in_valid7 = 1'b0;
      check("level_first_time", 32'(first), 32'd9);
      check("level_period", 32'(second - first), 32'd9);
      prev7 = model(57);
      @(negedge CLOCK_50);
      @(negedge CLOCK_50);

      // Reset in shift cycle 4 of a conversion of 85
      in_valid7 = 1'b1;
      in_data7  = 7'd85;
      @(negedge CLOCK_50);
      in_valid7 = 1'b0;
      repeat (4) @(negedge CLOCK_50);
      check("midrst_busy_before", 32'(busy7), 32'd1);
      rst = 1'b1;
      @(negedge CLOCK_50);
      rst = 1'b0;
      check("midrst_digits", 32'({bcd_hund7, bcd_tens7, bcd_ones7, over99_7}), 32'd0);
      check("midrst_flags", 32'({out_valid7, in_ready7, busy7}), 32'b010);
      check("midrst_state", 32'(dbg_state7), 32'(ST_IDLE));
      saw_ov = 1'b0;
      for (int k = 0; k < 12; k++) begin
         @(negedge CLOCK_50);
         if (out_valid7) saw_ov = 1'b1;
      end
      check("midrst_no_out_valid", 32'(saw_ov), 32'd0);
      prev7 = '0;
      exp_q.push_back(model(85));
      conv7(7'd85);

      // Sweep 0..127 on W=7
      for (int v = 0; v < 128; v++) begin
         exp_q.push_back(model(v));
         conv7(7'(v));
      end

      // Sweep 0..511 on W=9
      for (int v = 0; v < 512; v++) begin
         exp_q.push_back(model(v));
         conv9(9'(v));
      end

      check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
